// File: rtl/sram_controller.sv
// sram_controller: 32-bit load/store responder using two 16-bit async SRAM accesses per request
// Ports: clk/rst (async, active low); rd_en/wr_en/address/write_data request from execute;
//        read_data registered load result; ready low while the pipeline must freeze;
//        SRAM_* drive the external 16-bit asynchronous SRAM.
module sram_controller #(
    parameter int BASE_ADDR   = 1024,
    parameter int SRAM_ADDR_W = 18,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [31:0]            address,
    input  logic [31:0]            write_data,
    output logic [31:0]            read_data,
    output logic                   ready,
    inout  wire  [15:0]            SRAM_DQ,
    output logic [SRAM_ADDR_W-1:0] SRAM_ADDR,
    output logic                   SRAM_WE_N,
    output logic                   SRAM_OE_N,
    output logic                   SRAM_CE_N,
    output logic                   SRAM_UB_N,
    output logic                   SRAM_LB_N
);
    localparam int IW = SRAM_ADDR_W - 1;
    localparam int CW = 4;

    typedef enum logic [1:0] {IDLE, LOW, HIGH, DONE} state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   is_wr_q, is_wr_d;
    logic [IW-1:0]          idx_q, idx_d;
    logic [31:0]            wdata_q, wdata_d;
    logic [15:0]            rbuf_q, rbuf_d;
    logic [31:0]            read_data_q, read_data_d;
    logic [SRAM_ADDR_W-1:0] sram_addr_q, sram_addr_d;
    logic                   we_n_q, we_n_d;
    logic                   oe_n_q, oe_n_d;
    logic                   ce_n_q, ce_n_d;
    logic                   be_n_q, be_n_d;
    logic                   dq_oe_q, dq_oe_d;
    logic [15:0]            dq_out_q, dq_out_d;
    logic                   last, act, hi;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        is_wr_d     = is_wr_q;
        idx_d       = idx_q;
        wdata_d     = wdata_q;
        rbuf_d      = rbuf_q;
        read_data_d = read_data_q;
        last        = cnt_q == CW'(WAIT_CYCLES - 1);
        case (state_q)
            IDLE: if (rd_en | wr_en) begin
                state_d = LOW;
                cnt_d   = '0;
                is_wr_d = wr_en;
                idx_d   = IW'((address - 32'(BASE_ADDR)) >> 2);
                wdata_d = write_data;
            end
            LOW: if (last) begin
                state_d = HIGH;
                cnt_d   = '0;
                rbuf_d  = is_wr_q ? rbuf_q : SRAM_DQ;
            end else cnt_d = cnt_q + 1'b1;
            HIGH: if (last) begin
                state_d     = DONE;
                cnt_d       = '0;
                read_data_d = is_wr_q ? read_data_q : {SRAM_DQ, rbuf_q};
            end else cnt_d = cnt_q + 1'b1;
            default: state_d = IDLE;
        endcase
        // SRAM pins are registered from the next state so they line up with the phase itself
        act         = (state_d == LOW) || (state_d == HIGH);
        hi          = state_d == HIGH;
        sram_addr_d = act ? {idx_d, hi} : '0;
        we_n_d      = !(act && is_wr_d);
        oe_n_d      = !(act && !is_wr_d);
        ce_n_d      = !act;
        be_n_d      = !act;
        dq_oe_d     = act && is_wr_d;
        dq_out_d    = hi ? wdata_d[31:16] : wdata_d[15:0];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            is_wr_q     <= 1'b0;
            idx_q       <= '0;
            wdata_q     <= '0;
            rbuf_q      <= '0;
            read_data_q <= '0;
            sram_addr_q <= '0;
            we_n_q      <= 1'b1;
            oe_n_q      <= 1'b1;
            ce_n_q      <= 1'b1;
            be_n_q      <= 1'b1;
            dq_oe_q     <= 1'b0;
            dq_out_q    <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            is_wr_q     <= is_wr_d;
            idx_q       <= idx_d;
            wdata_q     <= wdata_d;
            rbuf_q      <= rbuf_d;
            read_data_q <= read_data_d;
            sram_addr_q <= sram_addr_d;
            we_n_q      <= we_n_d;
            oe_n_q      <= oe_n_d;
            ce_n_q      <= ce_n_d;
            be_n_q      <= be_n_d;
            dq_oe_q     <= dq_oe_d;
            dq_out_q    <= dq_out_d;
        end
    end

    // a pending request in IDLE already stalls, so the request cycle counts as a stall cycle
    assign ready     = (state_q == DONE) || (state_q == IDLE && !(rd_en | wr_en));
    assign read_data = read_data_q;
    assign SRAM_DQ   = dq_oe_q ? dq_out_q : 16'hzzzz;
    assign SRAM_ADDR = sram_addr_q;
    assign SRAM_WE_N = we_n_q;
    assign SRAM_OE_N = oe_n_q;
    assign SRAM_CE_N = ce_n_q;
    assign SRAM_UB_N = be_n_q;
    assign SRAM_LB_N = be_n_q;
endmodule

// File: tb/tb_sram_controller.sv
// tb_sram_controller: vector table plus write/read scoreboards against an SRAM model
module tb_sram_controller;
    logic        clk = 1'b0;
    logic        rst, rd_en, wr_en, ready;
    logic [31:0] address, write_data, read_data, last_rd;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        we_n, oe_n, ce_n, ub_n, lb_n;

    logic        b_rd, b_wr, b_ready;
    logic [31:0] b_addr, b_wd, b_rdata;
    wire  [15:0] b_dq;
    logic [17:0] b_sram_addr;
    logic        b_we_n, b_oe_n, b_ce_n, b_ub_n, b_lb_n;

    int n_chk = 0;
    int n_fail = 0;

    logic [15:0] mem [0:262143];
    logic [33:0] wq[$];
    logic [31:0] rq[$];

    typedef struct {
        logic        rd, wr;
        logic [31:0] addr, wdata, exp_rd;
        logic [17:0] exp_lo;
    } vec_t;
    vec_t vt[9];

    always #5 clk = ~clk;

    sram_controller dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en), .address(address),
        .write_data(write_data), .read_data(read_data), .ready(ready), .SRAM_DQ(sram_dq),
        .SRAM_ADDR(sram_addr), .SRAM_WE_N(we_n), .SRAM_OE_N(oe_n), .SRAM_CE_N(ce_n),
        .SRAM_UB_N(ub_n), .SRAM_LB_N(lb_n)
    );

    sram_controller #(.WAIT_CYCLES(1)) dut1 (
        .clk(clk), .rst(rst), .rd_en(b_rd), .wr_en(b_wr), .address(b_addr),
        .write_data(b_wd), .read_data(b_rdata), .ready(b_ready), .SRAM_DQ(b_dq),
        .SRAM_ADDR(b_sram_addr), .SRAM_WE_N(b_we_n), .SRAM_OE_N(b_oe_n), .SRAM_CE_N(b_ce_n),
        .SRAM_UB_N(b_ub_n), .SRAM_LB_N(b_lb_n)
    );

    assign sram_dq = (!ce_n && !oe_n && we_n) ? mem[sram_addr] : 16'hzzzz;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    always @(posedge clk) begin
        if (!ce_n && !we_n) begin
            mem[sram_addr] <= sram_dq;
            if (wq.size() == 0) check("unexpected_write", {sram_addr, sram_dq}, 34'h0);
            else check("sram_write", {sram_addr, sram_dq}, wq.pop_front());
        end
    end

    always @(negedge clk) if (rst && !oe_n) check("oe_only_in_stall", ready, 0);

    task automatic run_txn(input vec_t v);
        int   stalls = 0;
        bit   done = 0;
        bit   got_lo = 0;
        logic [17:0] lo_seen = '1;
        logic [31:0] exp;
        @(negedge clk);
        check("idle_ready", ready, 1);
        check("idle_rdata_held", read_data, last_rd);
        @(posedge clk);
        #1;
        rd_en = v.rd;
        wr_en = v.wr;
        address = v.addr;
        write_data = v.wdata;
        if (v.wr) begin
            repeat (2) wq.push_back({v.exp_lo, v.wdata[15:0]});
            repeat (2) wq.push_back({v.exp_lo | 18'd1, v.wdata[31:16]});
        end else rq.push_back(v.exp_rd);
        for (int c = 0; c < 40 && !done; c++) begin
            @(negedge clk);
            if (ready) done = 1;
            else begin
                stalls++;
                if (!ce_n && !got_lo) begin
                    got_lo = 1;
                    lo_seen = sram_addr;
                end
                if (c > 0) begin
                    address = $urandom;
                    write_data = $urandom;
                end
            end
        end
        check("done_reached", done, 1);
        check("stall_cycles", stalls, 5);
        check("low_word_addr", lo_seen, v.exp_lo);
        if (!v.wr && rq.size() > 0) begin
            exp = rq.pop_front();
            check("read_data", read_data, exp);
            last_rd = exp;
        end
        rd_en = 0;
        wr_en = 0;
    endtask

    initial begin
        vt[0] = '{0, 1, 32'd1024, 32'hDEADBEEF, 32'h0, 18'h00000};
        vt[1] = '{1, 0, 32'd1024, 32'h0, 32'hDEADBEEF, 18'h00000};
        vt[2] = '{1, 1, 32'd1032, 32'h12345678, 32'h0, 18'h00004};
        vt[3] = '{1, 0, 32'd1032, 32'h0, 32'h12345678, 18'h00004};
        vt[4] = '{0, 1, 32'd0, 32'hCAFEF00D, 32'h0, 18'h3FE00};
        vt[5] = '{1, 0, 32'd0, 32'h0, 32'hCAFEF00D, 18'h3FE00};
        vt[6] = '{0, 1, 32'd1027, 32'h0BADC0DE, 32'h0, 18'h00000};
        vt[7] = '{0, 1, 32'd1040, 32'h33334444, 32'h0, 18'h00008};
        vt[8] = '{1, 0, 32'd1024, 32'h0, 32'h0BADC0DE, 18'h00000};
        rst = 0; rd_en = 0; wr_en = 0; address = 0; write_data = 0; last_rd = 0;
        b_rd = 0; b_wr = 0; b_addr = 0; b_wd = 0;
        repeat (2) @(negedge clk);
        rst = 1;
        @(negedge clk);
        check("rst_ready", ready, 1);
        check("rst_ctrl_n", {we_n, oe_n, ce_n, ub_n, lb_n}, 5'b11111);
        check("rst_addr", sram_addr, 0);
        check("rst_rdata", read_data, 0);
        foreach (vt[i]) run_txn(vt[i]);
        // store to words 8/9 interrupted by reset during its upper half
        @(negedge clk);
        @(posedge clk);
        #1;
        wr_en = 1;
        address = 32'd1040;
        write_data = 32'h11112222;
        repeat (2) wq.push_back({18'h00008, 16'h2222});
        repeat (4) @(negedge clk);
        check("pre_rst_high_addr", sram_addr, 18'h00009);
        rst = 0;
        wr_en = 0;
        #1;
        check("arst_ctrl_n", {we_n, oe_n, ce_n, ub_n, lb_n}, 5'b11111);
        check("arst_addr", sram_addr, 0);
        check("arst_ready", ready, 1);
        check("arst_rdata", read_data, 0);
        repeat (2) @(negedge clk);
        rst = 1;
        last_rd = 0;
        check("abandoned_writes", wq.size(), 0);
        run_txn('{1, 0, 32'd1040, 32'h0, 32'h33332222, 18'h00008});
        // single-wait-cycle instance with a below-base address
        @(posedge clk);
        #1;
        b_wr = 1;
        b_addr = 32'd1020;
        b_wd = 32'hA5A55A5A;
        @(negedge clk);
        check("w1_req_ready", b_ready, 0);
        @(negedge clk);
        check("w1_low", {b_ready, b_we_n, b_sram_addr, b_dq}, {1'b0, 1'b0, 18'h3FFFE, 16'h5A5A});
        b_addr = 32'd2048;
        @(negedge clk);
        check("w1_high", {b_ready, b_we_n, b_sram_addr, b_dq}, {1'b0, 1'b0, 18'h3FFFF, 16'hA5A5});
        @(negedge clk);
        check("w1_done", {b_ready, b_we_n, b_ce_n}, 3'b111);
        b_wr = 0;
        @(negedge clk);
        check("wq_drained", wq.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/sram_controller.md
Name: sram_controller

Overview:
- Memory-side responder for the load/store request produced by the execute stage.
- Consumes rd_en/wr_en, the ALU result as a byte address, and the forwarded second operand as store data.
- Performs each 32-bit access as two 16-bit accesses to the external asynchronous SRAM.
- Holds ready low for the whole access so the hazard/freeze logic stalls the pipeline, then returns load data to the MEM/WB path.

Parameters:
- BASE_ADDR, 1024: byte address that maps to SRAM word 0.
- SRAM_ADDR_W, 18: external SRAM address width, in 16-bit words.
- WAIT_CYCLES, 2: clock cycles spent on each 16-bit half-access; legal range 1..15.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- rd_en  in  1  load request from the execute/MEM pipeline register.
- wr_en  in  1  store request; wins over rd_en when both are high.
- address  in  32  byte address (ALU result).
- write_data  in  32  store data (forwarded second register operand).
- read_data  out  32  load result; registered.
- ready  out  1  combinational; 0 means freeze the pipeline.
- SRAM_DQ  inout  16  SRAM data bus.
- SRAM_ADDR  out  SRAM_ADDR_W  SRAM word address.
- SRAM_WE_N  out  1  write enable, active low.
- SRAM_OE_N  out  1  output enable, active low.
- SRAM_CE_N  out  1  chip enable, active low.
- SRAM_UB_N  out  1  upper byte enable, active low.
- SRAM_LB_N  out  1  lower byte enable, active low.

Behaviour:
- States: IDLE, LOW, HIGH, DONE. An internal cycle counter runs 0..WAIT_CYCLES-1.
- Reset (rst=0, async):
  - state=IDLE, counter=0, read_data=0, latched address/data/op=0.
  - WE_N/OE_N/CE_N/UB_N/LB_N = 1, SRAM_ADDR=0, SRAM_DQ high-Z.
  - Reset mid-access abandons the access immediately; no partial write completes after reset.
- IDLE:
  - ready = ~(rd_en | wr_en).
  - On an edge with a request: latch op (write if wr_en), word index, and write_data; go to LOW with counter=0.
- Word index = (address - BASE_ADDR) >> 2, truncated to SRAM_ADDR_W-1 bits.
  - Below-base and out-of-range addresses wrap modulo the SRAM size; no error is raised.
  - address[1:0] is ignored.
- LOW: SRAM_ADDR = {index, 1'b0}; carries bits [15:0].
- HIGH: SRAM_ADDR = {index, 1'b1}; carries bits [31:16].
- Common to LOW and HIGH:
  - CE_N=0, UB_N=0, LB_N=0.
  - Write: WE_N=0, OE_N=1, DQ driven with the latched half.
  - Read: WE_N=1, OE_N=0, DQ high-Z.
  - Each phase lasts exactly WAIT_CYCLES cycles. On the edge ending the phase (counter=WAIT_CYCLES-1), a read captures SRAM_DQ into the matching half of an internal buffer.
  - LOW→HIGH and HIGH→DONE each reset the counter.
- DONE:
  - ready=1. Read: read_data takes the full buffer on the edge entering DONE and is visible throughout DONE.
  - SRAM controls are deasserted and DQ is high-Z.
  - Always returns to IDLE on the next edge. A request still present in that IDLE cycle is treated as new; the pipeline has advanced, so it belongs to the next instruction.
- ready is 0 in LOW and HIGH.
- Latency: the request cycle plus 2*WAIT_CYCLES cycles with ready=0, then one DONE cycle with ready=1. With the default that is 5 stall cycles, with ready high on the 6th.
- read_data holds its value until the next read completes; writes never alter it.
- Changes on address, write_data, rd_en or wr_en after acceptance are ignored until IDLE.
- SRAM_DQ is never driven outside write phases, so there is no bus contention in IDLE or DONE.

Test Plan:
- Reset released, no request → ready=1; all SRAM_*_N=1; DQ=Z; read_data=0.
- Store 0xDEADBEEF at address 1024 → ready low 5 cycles. SRAM word 0 written 0xBEEF (WE_N=0 for 2 cycles), then word 1 written 0xDEAD. ready=1 in DONE.
- Load address 1024 from an SRAM model holding those halves → read_data=0xDEADBEEF in DONE and held afterwards; OE_N=0 only in LOW/HIGH.
- rd_en and wr_en both high, address 1032, data 0x12345678 → write performed at SRAM words 4/5. Toggle address mid-access → still words 4/5.
- rst pulsed low during HIGH of a store → outputs return to reset values asynchronously; no WE_N pulse after reset; the next request starts from LOW.
- WAIT_CYCLES=1, address 1020 → 3 stall cycles; the index wraps to SRAM word pair 0x3FFFE/0x3FFFF.
